// File: rtl/regdump_uart_tx.sv
// Dumps x1..xNUM_REGS over an 8N1 UART as 0xA5 followed by each register, little-endian bytes.
// Optional XOR trailer byte over the payload when REGDUMP_CHECKSUM_EN is defined.
module regdump_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned NUM_REGS     = 10,
   parameter int unsigned DATA_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic [4:0]            dbg_reg_addr,
   input  logic [DATA_WIDTH-1:0] dbg_reg_data,
   output logic                  tx,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned CW       = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [4:0]    LAST_REG = 5'(NUM_REGS);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         clk_cnt;
   logic [2:0]            bit_cnt;
   logic [1:0]            byte_cnt;
   logic [4:0]            reg_idx;
   logic [7:0]            shreg;
   logic [DATA_WIDTH-1:0] reg_buf;
   logic                  bit_end;
   logic                  last_byte;
`ifdef REGDUMP_CHECKSUM_EN
   logic [7:0]            csum;
   logic                  trailer;
`endif

   assign bit_end   = (clk_cnt == BIT_LAST);
   assign last_byte = (byte_cnt == 2'd3);
   assign busy      = (state_q != IDLE);

   always_comb begin
      tx = 1'b1;
      if (state_q == START)
         tx = 1'b0;
      else if (state_q == DATA)
         tx = shreg[0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // The header is treated as an already-finished register (byte_cnt=3, reg_idx=0),
   // so its stop bit naturally leads into the first FETCH.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (start) state_d = START;
         FETCH: state_d = LOAD;
         LOAD:  state_d = START;
         START: if (bit_end) state_d = DATA;
         DATA:  if (bit_end && bit_cnt == 3'd7) state_d = STOP;
         STOP: begin
            if (bit_end) begin
               if (!last_byte)
                  state_d = START;
               else if (reg_idx != LAST_REG)
                  state_d = FETCH;
`ifdef REGDUMP_CHECKSUM_EN
               else if (!trailer)
                  state_d = START;
`endif
               else
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_cnt      <= '0;
         bit_cnt      <= '0;
         byte_cnt     <= '0;
         reg_idx      <= '0;
         shreg        <= '0;
         reg_buf      <= '0;
         dbg_reg_addr <= '0;
         done         <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
         csum         <= '0;
         trailer      <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (state_q == START || state_q == DATA || state_q == STOP)
            clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
         else
            clk_cnt <= '0;

         case (state_q)
            IDLE: begin
               if (start) begin
                  shreg    <= 8'hA5;
                  byte_cnt <= 2'd3;
                  reg_idx  <= '0;
                  bit_cnt  <= '0;
`ifdef REGDUMP_CHECKSUM_EN
                  csum     <= '0;
                  trailer  <= 1'b0;
`endif
               end
            end
            LOAD: begin
               reg_buf  <= dbg_reg_data;
               shreg    <= dbg_reg_data[7:0];
               byte_cnt <= '0;
`ifdef REGDUMP_CHECKSUM_EN
               csum <= csum ^ dbg_reg_data[7:0] ^ dbg_reg_data[15:8]
                            ^ dbg_reg_data[23:16] ^ dbg_reg_data[31:24];
`endif
            end
            DATA: begin
               if (bit_end) begin
                  shreg   <= {1'b0, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (!last_byte) begin
                     shreg    <= reg_buf[15:8];
                     reg_buf  <= reg_buf >> 8;
                     byte_cnt <= byte_cnt + 2'd1;
                  end else if (reg_idx != LAST_REG) begin
                     reg_idx      <= reg_idx + 5'd1;
                     dbg_reg_addr <= reg_idx + 5'd1;
                  end
`ifdef REGDUMP_CHECKSUM_EN
                  else if (!trailer) begin
                     shreg   <= csum;
                     trailer <= 1'b1;
                  end
`endif
                  else
                     done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_regdump_uart_tx.sv
// Scoreboard bench for regdump_uart_tx: expected bytes are queued at start, a UART
// decoder on tx pops and compares them along with inter-byte spacing.
module tb_regdump_uart_tx;
   localparam int unsigned CPB  = 4;
   localparam int unsigned NREG = 2;
`ifdef REGDUMP_CHECKSUM_EN
   localparam int unsigned FRAME_LEN = 10;
`else
   localparam int unsigned FRAME_LEN = 9;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [4:0]  dbg_reg_addr;
   logic [31:0] dbg_reg_data;
   logic        tx, busy, done;
   logic [31:0] regs [0:31];

   always #5 clk = ~clk;
   assign dbg_reg_data = regs[dbg_reg_addr];

   regdump_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_REGS(NREG)) dut (
      .clk(clk), .reset(reset), .start(start),
      .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data),
      .tx(tx), .busy(busy), .done(done)
   );

   typedef struct {
      logic [7:0]  data;
      int unsigned gap;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e_mon;
   logic [4:0]  addr_log[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0, bytes_rx = 0, done_cnt = 0;

   // Hand-computed payloads (little-endian register bytes) and their XOR trailers.
   logic [7:0] f1 [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
   logic [7:0] f2 [8] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h7E, 8'h01, 8'h80};
   logic [7:0] cs1 = 8'h2A;
   logic [7:0] cs2 = 8'h01;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
      end
   endtask

   task automatic push_frame(input logic [7:0] pay [8], input logic [7:0] cs);
      exp_t e;
      e.data = 8'hA5; e.gap = 0;
      exp_q.push_back(e);
      for (int i = 0; i < 8; i++) begin
         e.data = pay[i];
         e.gap  = (i % 4 == 0) ? 10*CPB + 2 : 10*CPB;
         exp_q.push_back(e);
      end
`ifdef REGDUMP_CHECKSUM_EN
      e.data = cs; e.gap = 10*CPB;
      exp_q.push_back(e);
`else
      if (cs === 8'hxx) $display("unused trailer value");
`endif
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(input int unsigned budget);
      int unsigned d0 = done_cnt;
      int unsigned n  = 0;
      while (done_cnt == d0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("done_within_budget", 32'(done_cnt != d0), 32'd1);
   endtask

   task automatic frame_checks(input int unsigned dn0, input int unsigned b0);
      @(negedge clk);
      chk("busy_after_done", 32'(busy), 32'd0);
      repeat (100) @(negedge clk);
      chk("done_count", done_cnt - dn0, 32'd1);
      chk("byte_count", bytes_rx - b0, FRAME_LEN);
      chk("queue_empty", exp_q.size(), 32'd0);
      chk("addr_changes", addr_log.size(), 32'd2);
      if (addr_log.size() == 2) begin
         chk("addr_first", 32'(addr_log[0]), 32'd1);
         chk("addr_second", 32'(addr_log[1]), 32'd2);
      end
   endtask

   // Monitor: done pulse, debug address changes, UART decoder + scoreboard.
   logic        prev_done = 1'b0;
   logic [4:0]  prev_addr = '0;
   logic        dec_active = 1'b0;
   int unsigned dec_cnt = 0, t_start = 0, t_last = 0;
   logic [7:0]  dec_sh = '0;

   always @(negedge clk) begin
      cyc++;
      if (done) begin
         done_cnt++;
         chk("busy_at_done", 32'(busy), 32'd0);
         chk("done_width", 32'(prev_done), 32'd0);
      end
      prev_done = done;
      if (busy && dbg_reg_addr != prev_addr) addr_log.push_back(dbg_reg_addr);
      prev_addr = dbg_reg_addr;

      if (reset) begin
         dec_active = 1'b0;
      end else if (!dec_active) begin
         if (tx === 1'b0) begin
            dec_active = 1'b1;
            dec_cnt    = 0;
            t_start    = cyc;
         end
      end else begin
         dec_cnt++;
         if (dec_cnt % CPB == 0) begin
            if (dec_cnt < 9*CPB) begin
               dec_sh = {tx, dec_sh[7:1]};
            end else begin
               chk("stop_bit", 32'(tx), 32'd1);
               dec_active = 1'b0;
               bytes_rx++;
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_byte: got 0x%0h expected none", dec_sh);
               end else begin
                  e_mon = exp_q.pop_front();
                  chk("byte", 32'(dec_sh), 32'(e_mon.data));
                  if (e_mon.gap != 0) chk("byte_spacing", t_start - t_last, e_mon.gap);
               end
               t_last = t_start;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned dn0, b0, bad;
      for (int i = 0; i < 32; i++) regs[i] = '0;
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_tx", 32'(tx), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_addr", 32'(dbg_reg_addr), 32'd0);
      reset = 1'b0;

      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      end
      chk("idle_quiet", bad, 32'd0);

      // Normal frame, with a second start during byte 3 that must be dropped.
      regs[1] = 32'h12345678;
      regs[2] = 32'hDEADBEEF;
      dn0 = done_cnt; b0 = bytes_rx;
      addr_log.delete();
      push_frame(f1, cs1);
      pulse_start();
      chk("busy_after_start", 32'(busy), 32'd1);
      repeat (3*10*CPB + 10) @(negedge clk);
      pulse_start();
      wait_done(800);
      frame_checks(dn0, b0);

      // Reset during header data bit 1 (a zero bit).
      pulse_start();
      repeat (9) @(negedge clk);
      chk("tx_data_bit_before_reset", 32'(tx), 32'd0);
      #1 reset = 1'b1;
      #1;
      chk("async_reset_tx", 32'(tx), 32'd1);
      chk("async_reset_busy", 32'(busy), 32'd0);
      chk("async_reset_addr", 32'(dbg_reg_addr), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (50) @(negedge clk);
      chk("abandoned_frame_bytes", bytes_rx - b0, FRAME_LEN);

      // Full frame after the aborted one.
      regs[1] = 32'h000000FF;
      regs[2] = 32'h80017E01;
      dn0 = done_cnt; b0 = bytes_rx;
      addr_log.delete();
      push_frame(f2, cs2);
      pulse_start();
      wait_done(800);
      frame_checks(dn0, b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
